// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell/winner codes, state enum and position decode for the turn sequencer
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_PL    = 2'b01;
  localparam logic [1:0] CELL_PC    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_PL   = 2'b01;
  localparam logic [1:0] WIN_PC   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_PL_WAIT,
    S_PC_WAIT,
    S_WRITE,
    S_CHECK,
    S_REJECT,
    S_OVER
  } state_t;

  // Out-of-range positions decode to zero, so they can never match an empty cell.
  function automatic logic [8:0] pos_to_onehot(input logic [3:0] pos);
    logic [8:0] oh;
    oh = '0;
    if (pos >= 4'd1 && pos <= 4'd9)
      oh = 9'd1 << (pos - 4'd1);
    return oh;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// rtl/move_sequencer_if.sv - request, board and result signals between move sources and the sequencer
interface move_sequencer_if;
  logic        play;
  logic [3:0]  player_pos;
  logic        pc_play;
  logic [3:0]  computer_pos;
  logic [17:0] board;
  logic [8:0]  PL_en;
  logic [8:0]  PC_en;
  logic        illegal_move;
  logic        turn;
  logic [1:0]  winner;
  logic        game_over;

  modport master (
    output play, player_pos, pc_play, computer_pos, board,
    input  PL_en, PC_en, illegal_move, turn, winner, game_over
  );

  modport slave (
    input  play, player_pos, pc_play, computer_pos, board,
    output PL_en, PC_en, illegal_move, turn, winner, game_over
  );
endinterface

// File: rtl/line_checker.sv
// rtl/line_checker.sv - combinational win/draw evaluation of the nine-cell board
module line_checker
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  output logic [1:0]  winner
);

  function automatic logic [1:0] line_code(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c);
    return (a != CELL_EMPTY && a == b && b == c) ? a : WIN_NONE;
  endfunction

  logic [1:0] c [9];
  logic [1:0] w;
  logic       full;

  always_comb begin
    full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      c[k] = board[2*k +: 2];
      if (c[k] == CELL_EMPTY)
        full = 1'b0;
    end
    // First matching line wins; only one side can own a line in real play.
    w = line_code(c[0], c[1], c[2]);
    if (w == WIN_NONE) w = line_code(c[3], c[4], c[5]);
    if (w == WIN_NONE) w = line_code(c[6], c[7], c[8]);
    if (w == WIN_NONE) w = line_code(c[0], c[3], c[6]);
    if (w == WIN_NONE) w = line_code(c[1], c[4], c[7]);
    if (w == WIN_NONE) w = line_code(c[2], c[5], c[8]);
    if (w == WIN_NONE) w = line_code(c[0], c[4], c[8]);
    if (w == WIN_NONE) w = line_code(c[2], c[4], c[6]);
    winner = (w != WIN_NONE) ? w : (full ? WIN_DRAW : WIN_NONE);
  end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - validates move requests, issues one-cycle cell writes and tracks turn/result
module move_sequencer
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input logic             clk,
  input logic             rst,
  move_sequencer_if.slave bus
);

  state_t     state;
  logic [1:0] check_win;
  logic [8:0] empty_mask;
  logic [8:0] pl_oh;
  logic [8:0] pc_oh;
  logic       pl_legal;
  logic       pc_legal;

  line_checker u_line_checker (
    .board  (bus.board),
    .winner (check_win)
  );

  always_comb begin
    empty_mask = '0;
    for (int k = 0; k < 9; k++)
      empty_mask[k] = (bus.board[2*k +: 2] == CELL_EMPTY);
  end

  assign pl_oh    = pos_to_onehot(bus.player_pos);
  assign pc_oh    = pos_to_onehot(bus.computer_pos);
  assign pl_legal = |(pl_oh & empty_mask);
  assign pc_legal = |(pc_oh & empty_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= FIRST_PLAYER ? S_PC_WAIT : S_PL_WAIT;
      bus.PL_en        <= '0;
      bus.PC_en        <= '0;
      bus.illegal_move <= 1'b0;
      bus.turn         <= FIRST_PLAYER;
      bus.winner       <= WIN_NONE;
      bus.game_over    <= 1'b0;
    end else begin
      // Enables and the reject pulse live for exactly one cycle.
      bus.PL_en        <= '0;
      bus.PC_en        <= '0;
      bus.illegal_move <= 1'b0;
      case (state)
        S_PL_WAIT: begin
          if (bus.play) begin
            if (pl_legal) begin
              bus.PL_en <= pl_oh;
              state     <= S_WRITE;
            end else begin
              bus.illegal_move <= 1'b1;
              state            <= S_REJECT;
            end
          end
        end
        S_PC_WAIT: begin
          if (bus.pc_play) begin
            if (pc_legal) begin
              bus.PC_en <= pc_oh;
              state     <= S_WRITE;
            end else begin
              bus.illegal_move <= 1'b1;
              state            <= S_REJECT;
            end
          end
        end
        S_WRITE: state <= S_CHECK;
        S_CHECK: begin
          if (check_win != WIN_NONE) begin
            bus.winner    <= check_win;
            bus.game_over <= 1'b1;
            state         <= S_OVER;
          end else begin
            bus.turn <= ~bus.turn;
            state    <= bus.turn ? S_PL_WAIT : S_PC_WAIT;
          end
        end
        S_REJECT: state <= bus.turn ? S_PC_WAIT : S_PL_WAIT;
        S_OVER:   state <= S_OVER;
        default:  state <= FIRST_PLAYER ? S_PC_WAIT : S_PL_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - self-checking bench for move_sequencer with a board register and game model
module tb_move_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [17:0] board_q;
  int total = 0;
  int bad = 0;

  move_sequencer_if bus ();

  move_sequencer #(.FIRST_PLAYER(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Position register that the sequencer writes through PL_en/PC_en.
  always @(posedge clk or posedge rst) begin
    if (rst) board_q <= '0;
    else
      for (int k = 0; k < 9; k++) begin
        if (bus.PL_en[k]) board_q[2*k +: 2] <= 2'b01;
        else if (bus.PC_en[k]) board_q[2*k +: 2] <= 2'b10;
      end
  end
  assign bus.board = board_q;

  // Game model: cells hold 0 empty, 1 player, 2 computer.
  int       m_cells [9];
  bit       m_turn;
  bit       m_over;
  bit [1:0] m_win;

  localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                  '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit [1:0] model_result();
    int filled = 0;
    for (int l = 0; l < 8; l++) begin
      int a = LINES[l][0];
      int b = LINES[l][1];
      int c = LINES[l][2];
      if (m_cells[a] != 0 && m_cells[a] == m_cells[b] && m_cells[b] == m_cells[c])
        return 2'(m_cells[a]);
    end
    for (int k = 0; k < 9; k++) if (m_cells[k] != 0) filled++;
    return (filled == 9) ? 2'b11 : 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.play = 1'b0; bus.pc_play = 1'b0;
    bus.player_pos = 4'd0; bus.computer_pos = 4'd0;
    @(negedge clk);
    chk("rst_pl_en", 32'(bus.PL_en), 32'd0);
    chk("rst_pc_en", 32'(bus.PC_en), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_move), 32'd0);
    chk("rst_turn", 32'(bus.turn), 32'd0);
    chk("rst_winner", 32'(bus.winner), 32'd0);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) m_cells[k] = 0;
    m_turn = 1'b0; m_over = 1'b0; m_win = 2'b00;
  endtask

  // One request from 'side' (both=1 raises both requests), checked against the model.
  task automatic run_req(input bit side, input logic [3:0] pos, input bit both,
                         output logic [8:0] o_pl, output logic [8:0] o_pc, output logic o_ill,
                         output logic o_turn, output logic [1:0] o_win);
    bit mover, active, legal;
    int p;
    logic [8:0] oh;
    p = int'(pos);
    mover = m_turn;
    active = !m_over && (both || side == m_turn);
    legal = active && p >= 1 && p <= 9 && m_cells[p-1] == 0;
    oh = legal ? (9'd1 << (p - 1)) : 9'd0;
    @(negedge clk);
    bus.player_pos = pos; bus.computer_pos = pos;
    bus.play = both || !side; bus.pc_play = both || side;
    @(posedge clk); #1;
    o_pl = bus.PL_en; o_pc = bus.PC_en; o_ill = bus.illegal_move;
    chk("pl_en", 32'(o_pl), 32'(mover == 1'b0 ? oh : 9'd0));
    chk("pc_en", 32'(o_pc), 32'(mover == 1'b1 ? oh : 9'd0));
    chk("illegal", 32'(o_ill), 32'(active && !legal));
    bus.play = 1'b0; bus.pc_play = 1'b0;
    if (legal) begin
      m_cells[p-1] = mover ? 2 : 1;
      @(posedge clk); #1;
      chk("en_one_cycle", 32'({bus.PL_en, bus.PC_en}), 32'd0);
      @(posedge clk); #1;
      m_win = model_result();
      if (m_win != 2'b00) m_over = 1'b1;
      else m_turn = !m_turn;
    end else if (active) begin
      @(posedge clk); #1;
      chk("illegal_one_cycle", 32'(bus.illegal_move), 32'd0);
    end
    chk("turn", 32'(bus.turn), 32'(m_turn));
    chk("winner", 32'(bus.winner), 32'(m_win));
    chk("game_over", 32'(bus.game_over), 32'(m_over));
    o_turn = bus.turn; o_win = bus.winner;
  endtask

  task automatic play_list(input int seq[$]);
    logic [8:0] a, b;
    logic c, t;
    logic [1:0] w;
    foreach (seq[i]) run_req(m_turn, 4'(seq[i]), 1'b0, a, b, c, t, w);
  endtask

  typedef struct {
    bit         side;
    logic [3:0] pos;
    bit         both;
    logic [8:0] pl;
    logic [8:0] pc;
    bit         ill;
    bit         turn;
    logic [1:0] win;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [8:0] g_pl, g_pc;
    logic g_ill, g_turn;
    logic [1:0] g_win;
    int r;
    bit side, both;
    logic [3:0] pos;

    vt[0]  = '{1'b0, 4'd5,  1'b0, 9'h010, 9'h000, 1'b0, 1'b1, 2'b00};
    vt[1]  = '{1'b1, 4'd5,  1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 2'b00};
    vt[2]  = '{1'b0, 4'd1,  1'b0, 9'h000, 9'h000, 1'b0, 1'b1, 2'b00};
    vt[3]  = '{1'b1, 4'd4,  1'b0, 9'h000, 9'h008, 1'b0, 1'b0, 2'b00};
    vt[4]  = '{1'b0, 4'd0,  1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 2'b00};
    vt[5]  = '{1'b0, 4'd10, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 2'b00};
    vt[6]  = '{1'b0, 4'd1,  1'b1, 9'h001, 9'h000, 1'b0, 1'b1, 2'b00};
    vt[7]  = '{1'b1, 4'd6,  1'b0, 9'h000, 9'h020, 1'b0, 1'b0, 2'b00};
    vt[8]  = '{1'b0, 4'd9,  1'b0, 9'h100, 9'h000, 1'b0, 1'b0, 2'b01};
    vt[9]  = '{1'b0, 4'd2,  1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 2'b01};
    vt[10] = '{1'b1, 4'd2,  1'b1, 9'h000, 9'h000, 1'b0, 1'b0, 2'b01};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      run_req(vt[i].side, vt[i].pos, vt[i].both, g_pl, g_pc, g_ill, g_turn, g_win);
      chk($sformatf("vec%0d_pl_en", i), 32'(g_pl), 32'(vt[i].pl));
      chk($sformatf("vec%0d_pc_en", i), 32'(g_pc), 32'(vt[i].pc));
      chk($sformatf("vec%0d_illegal", i), 32'(g_ill), 32'(vt[i].ill));
      chk($sformatf("vec%0d_turn", i), 32'(g_turn), 32'(vt[i].turn));
      chk($sformatf("vec%0d_winner", i), 32'(g_win), 32'(vt[i].win));
    end

    do_reset();
    play_list('{1, 4, 2, 5, 3});
    chk("row_win_winner", 32'(bus.winner), 32'd1);
    chk("row_win_game_over", 32'(bus.game_over), 32'd1);

    do_reset();
    play_list('{1, 2, 3, 5, 4, 6, 8, 7, 9});
    chk("draw_winner", 32'(bus.winner), 32'd3);

    do_reset();
    play_list('{1, 3, 2, 5, 4, 7});
    chk("diag_pc_winner", 32'(bus.winner), 32'd2);

    // Reset landing while the write enable is live.
    do_reset();
    @(negedge clk);
    bus.player_pos = 4'd5; bus.play = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_pl_en", 32'(bus.PL_en), 32'h010);
    bus.play = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_pl_en", 32'(bus.PL_en), 32'd0);
    chk("async_rst_turn", 32'(bus.turn), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_board", 32'(board_q), 32'd0);
    run_req(1'b0, 4'd5, 1'b0, g_pl, g_pc, g_ill, g_turn, g_win);

    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int i = 0; i < 40 && !m_over; i++) begin
        r = $urandom_range(0, 9);
        both = (r == 0);
        side = (r == 1) ? !m_turn : m_turn;
        pos = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
        run_req(side, pos, both, g_pl, g_pc, g_ill, g_turn, g_win);
      end
      run_req(1'b0, 4'($urandom_range(1, 9)), 1'b1, g_pl, g_pc, g_ill, g_turn, g_win);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
